// File: rtl/sprite_seq_pkg.sv
// Shared definitions for the sprite frame sequencer.
//   seq_state_t : sequencer states
//   PIX_*       : pix_src encodings presented to the colour mux
//   cw()        : counter/address width for n distinct values (minimum 1)
package sprite_seq_pkg;

  typedef enum logic [2:0] {
    S_BG     = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAW   = 3'd2,
    S_WAIT   = 3'd3,
    S_ERASE  = 3'd4,
    S_UPDATE = 3'd5
  } seq_state_t;

  localparam int unsigned PIX_SRC_W = 2;
  localparam logic [PIX_SRC_W-1:0] PIX_BG    = 2'd0;
  localparam logic [PIX_SRC_W-1:0] PIX_SPR   = 2'd1;
  localparam logic [PIX_SRC_W-1:0] PIX_ERASE = 2'd2;

  function automatic int unsigned cw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_frame_sequencer_rect_scanner.sv
// rect_scanner: raster col/row counter shared by the background fill and the
// per-sprite draw/erase passes. Column is the inner loop. The counter wraps
// back to (0,0) after the last pixel so consecutive rectangles chain directly.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   start        : synchronous clear to (0,0)
//   en           : advance one pixel
//   sel_bg       : 1 = background geometry, 0 = sprite geometry
//   col, row     : current offsets
//   done         : current pixel is the last one of the selected rectangle
module rect_scanner #(
  parameter int unsigned BG_W  = 160,
  parameter int unsigned BG_H  = 120,
  parameter int unsigned SPR_W = 4,
  parameter int unsigned SPR_H = 4,
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             en,
  input  logic             sel_bg,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             done
);

  logic [COL_W-1:0] col_max;
  logic [ROW_W-1:0] row_max;

  assign col_max = sel_bg ? COL_W'(BG_W - 1) : COL_W'(SPR_W - 1);
  assign row_max = sel_bg ? ROW_W'(BG_H - 1) : ROW_W'(SPR_H - 1);
  assign done    = (col == col_max) && (row == row_max);

  // Raster advance with wrap at the rectangle edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == col_max) begin
        col <= '0;
        row <= (row == row_max) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// sprite_frame_sequencer: paints the background once, then loops
// LOAD -> DRAW (all sprites) -> WAIT (FRAME_WAIT ticks) -> ERASE -> UPDATE,
// driving the vga plot port one pixel per clock.
// Optional macro SPRITE_TRANSPARENT_EN: when defined, DRAW pixels plot only
// where pix_opaque is high; timing is unchanged.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   frame_tick             : one-cycle pulse per video frame
//   spr_x/spr_y/spr_style  : packed per-sprite position and style
//   pix_opaque             : sprite ROM opacity (macro builds only)
//   plot, vga_x, vga_y     : plotter write enable and coordinates
//   pix_src                : colour source (background / sprite / erase)
//   spr_idx, cur_style     : current sprite and its latched style
//   spr_col, spr_row       : sprite ROM address offsets
//   upd_strobe             : request game logic to advance positions
//   busy_bg                : background fill in progress
module sprite_frame_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SPR_W       = 4,
  parameter int unsigned SPR_H       = 4,
  parameter int unsigned BG_W        = 160,
  parameter int unsigned BG_H        = 120,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned STYLE_W     = 2,
  parameter int unsigned FRAME_WAIT  = 15,
  localparam int unsigned IDX_W      = cw(NUM_SPRITES),
  localparam int unsigned SCOL_W     = cw(SPR_W),
  localparam int unsigned SROW_W     = cw(SPR_H)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_tick,
  input  logic [NUM_SPRITES*X_W-1:0]     spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0]     spr_y,
  input  logic [NUM_SPRITES*STYLE_W-1:0] spr_style,
  input  logic                           pix_opaque,
  output logic                           plot,
  output logic [X_W-1:0]                 vga_x,
  output logic [Y_W-1:0]                 vga_y,
  output logic [PIX_SRC_W-1:0]           pix_src,
  output logic [IDX_W-1:0]               spr_idx,
  output logic [STYLE_W-1:0]             cur_style,
  output logic [SCOL_W-1:0]              spr_col,
  output logic [SROW_W-1:0]              spr_row,
  output logic                           upd_strobe,
  output logic                           busy_bg
);

  localparam int unsigned COL_W  = (cw(BG_W) > SCOL_W) ? cw(BG_W) : SCOL_W;
  localparam int unsigned ROW_W  = (cw(BG_H) > SROW_W) ? cw(BG_H) : SROW_W;
  localparam int unsigned TICK_W = cw(FRAME_WAIT);

  seq_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TICK_W-1:0] tick_q;
  logic             bg_go_q;   // holds off the first plot until one clock after reset release
  logic [X_W-1:0]     lx [NUM_SPRITES];
  logic [Y_W-1:0]     ly [NUM_SPRITES];
  logic [STYLE_W-1:0] ls [NUM_SPRITES];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             scan_done;
  logic             scan_en;
  logic             scan_start;
  logic             last_spr;
  logic             in_spr;

  assign in_spr     = (state_q == S_DRAW) || (state_q == S_ERASE);
  assign scan_en    = ((state_q == S_BG) && bg_go_q) || in_spr;
  assign scan_start = (state_q == S_LOAD) || (state_q == S_WAIT);
  assign last_spr   = (idx_q == IDX_W'(NUM_SPRITES - 1));

  rect_scanner #(
    .BG_W (BG_W),
    .BG_H (BG_H),
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (scan_start),
    .en     (scan_en),
    .sel_bg (state_q == S_BG),
    .col    (col),
    .row    (row),
    .done   (scan_done)
  );

  // Sequencer state, sprite index, tick counter and position latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BG;
      idx_q   <= '0;
      tick_q  <= '0;
      bg_go_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lx[i] <= '0;
        ly[i] <= '0;
        ls[i] <= '0;
      end
    end else begin
      bg_go_q <= 1'b1;
      case (state_q)
        S_BG: begin
          if (bg_go_q && scan_done) state_q <= S_LOAD;
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            lx[i] <= spr_x[i*X_W +: X_W];
            ly[i] <= spr_y[i*Y_W +: Y_W];
            ls[i] <= spr_style[i*STYLE_W +: STYLE_W];
          end
          idx_q   <= '0;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (scan_done) begin
            if (last_spr) begin
              idx_q   <= '0;
              tick_q  <= '0;
              state_q <= S_WAIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (tick_q == TICK_W'(FRAME_WAIT - 1)) state_q <= S_ERASE;
            else                                    tick_q  <= tick_q + TICK_W'(1);
          end
        end
        S_ERASE: begin
          if (scan_done) begin
            if (last_spr) begin
              idx_q   <= '0;
              state_q <= S_UPDATE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_UPDATE: state_q <= S_LOAD;
        default:  state_q <= S_BG;
      endcase
    end
  end

`ifdef SPRITE_TRANSPARENT_EN
  logic draw_plot;
  assign draw_plot = pix_opaque;
`else
  logic draw_plot;
  logic unused_pix_opaque;
  assign draw_plot         = 1'b1;
  assign unused_pix_opaque = pix_opaque;
`endif

  assign spr_idx = idx_q;

  // Moore output decode; sprite-only fields read zero outside DRAW/ERASE
  always_comb begin
    plot       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    pix_src    = PIX_BG;
    cur_style  = '0;
    spr_col    = '0;
    spr_row    = '0;
    upd_strobe = 1'b0;
    busy_bg    = 1'b0;
    case (state_q)
      S_BG: begin
        busy_bg = 1'b1;
        plot    = bg_go_q;
        vga_x   = X_W'(col);
        vga_y   = Y_W'(row);
      end
      S_DRAW, S_ERASE: begin
        vga_x     = lx[idx_q] + X_W'(col);
        vga_y     = ly[idx_q] + Y_W'(row);
        cur_style = ls[idx_q];
        spr_col   = SCOL_W'(col);
        spr_row   = SROW_W'(row);
        if (state_q == S_DRAW) begin
          pix_src = PIX_SPR;
          plot    = draw_plot;
        end else begin
          pix_src = PIX_ERASE;
          plot    = 1'b1;
        end
      end
      S_UPDATE: upd_strobe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Directed bench for sprite_frame_sequencer with a small 8x4 background,
// two 4x4 sprites and FRAME_WAIT=2. All outputs are packed into one word per
// cycle and compared against hand-derived expectations.
module tb_sprite_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [15:0] spr_x;
  logic [13:0] spr_y;
  logic [3:0]  spr_style;
  logic        pix_opaque;
  logic        plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [1:0]  pix_src;
  logic [0:0]  spr_idx;
  logic [1:0]  cur_style;
  logic [1:0]  spr_col;
  logic [1:0]  spr_row;
  logic        upd_strobe;
  logic        busy_bg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Sprite ROM stand-in: top-left pixel of every sprite is transparent
  assign pix_opaque = !((spr_col == 2'd0) && (spr_row == 2'd0));

  sprite_frame_sequencer #(
    .NUM_SPRITES(2), .SPR_W(4), .SPR_H(4), .BG_W(8), .BG_H(4),
    .X_W(8), .Y_W(7), .STYLE_W(2), .FRAME_WAIT(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_style (spr_style),
    .pix_opaque(pix_opaque),
    .plot      (plot),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .pix_src   (pix_src),
    .spr_idx   (spr_idx),
    .cur_style (cur_style),
    .spr_col   (spr_col),
    .spr_row   (spr_row),
    .upd_strobe(upd_strobe),
    .busy_bg   (busy_bg)
  );

  function automatic logic [31:0] pack(input logic p, input logic [1:0] src,
                                       input logic idx, input logic [1:0] sty,
                                       input logic [1:0] c, input logic [1:0] r,
                                       input logic [7:0] x, input logic [6:0] y,
                                       input logic upd, input logic bsy);
    return {5'd0, p, src, idx, sty, c, r, x, y, upd, bsy};
  endfunction

  function automatic logic [31:0] obs();
    return pack(plot, pix_src, spr_idx[0], cur_style, spr_col, spr_row,
                vga_x, vga_y, upd_strobe, busy_bg);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full background raster followed by the single LOAD cycle
  task automatic chk_bg();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        check("bg", obs(), pack(1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'(x), 7'(y), 1'b0, 1'b1));
        step();
      end
    end
    check("load", obs(), 32'd0);
    step();
  endtask

  // npix pixels of one sprite pass; optionally pulses frame_tick after pixel tick_at
  task automatic chk_sprite(input string tag, input int src, input int s,
                            input int x0, input int y0, input int sty,
                            input int npix, input int tick_at);
    logic p;
    for (int k = 0; k < npix; k++) begin
      int c = k % 4;
      int r = k / 4;
`ifdef SPRITE_TRANSPARENT_EN
      p = (src == 2) ? 1'b1 : ((c != 0) || (r != 0));
`else
      p = 1'b1;
`endif
      check(tag, obs(), pack(p, 2'(src), 1'(s), 2'(sty), 2'(c), 2'(r),
                             8'(x0 + c), 7'(y0 + r), 1'b0, 1'b0));
      frame_tick = (k == tick_at);
      step();
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    spr_x      = {8'd30, 8'd10};
    spr_y      = {7'd5, 7'd20};
    spr_style  = {2'd2, 2'd1};
    #1;
    check("reset", obs(), pack(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0, 7'd0, 1'b0, 1'b1));
    @(negedge clk) reset_n = 1'b1;
    step();
    chk_bg();

    // First frame; tick during DRAW must be ignored
    chk_sprite("draw0", 1, 0, 10, 20, 1, 16, 5);
    chk_sprite("draw1", 1, 1, 30, 5, 2, 16, -1);

    // WAIT: new positions appear, two ticks seven cycles apart
    check("wait0", obs(), 32'd0);
    spr_x     = {8'd1, 8'd254};
    spr_y     = {7'd50, 7'd100};
    spr_style = {2'd3, 2'd0};
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("wait", obs(), 32'd0);
      step();
    end
    check("wait_last", obs(), 32'd0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;

    // ERASE uses the positions latched at LOAD
    chk_sprite("erase0", 2, 0, 10, 20, 1, 16, -1);
    chk_sprite("erase1", 2, 1, 30, 5, 2, 16, -1);
    check("update", obs(), pack(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0, 7'd0, 1'b1, 1'b0));
    step();
    check("load2", obs(), 32'd0);
    step();

    // Second frame picks up new values; x wraps 254,255,0,1
    chk_sprite("wrap0", 1, 0, 254, 100, 0, 16, -1);
    chk_sprite("draw1b", 1, 1, 1, 50, 3, 3, -1);

    // Asynchronous reset in the middle of a sprite
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid", obs(), pack(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0, 7'd0, 1'b0, 1'b1));
    @(negedge clk) reset_n = 1'b1;
    step();
    chk_bg();
    chk_sprite("post_rst", 1, 0, 254, 100, 0, 4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
